// File: rtl/dp_ram_fifo_ctrl.sv
// dp_ram_fifo_ctrl: single-clock FIFO controller in front of a dual-port RAM
// wrapper (read port A, write port B, 1-cycle read latency), with a 2-entry
// registered output stage feeding the pop stream.
// Optional feature macro: DP_RAM_FIFO_WR_BYPASS_EN -- issue a same-cycle read
// of the word being pushed into an empty RAM region, relying on the wrapper's
// write-bypass; push-to-pop latency drops from 3 to 2 cycles.
module dp_ram_fifo_ctrl #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                    CLK,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    push_valid,
    output logic                    push_ready,
    input  logic [DATA_WIDTH-1:0]   push_data,
    output logic                    pop_valid,
    input  logic                    pop_ready,
    output logic [DATA_WIDTH-1:0]   pop_data,
    output logic [ADDR_WIDTH+1:0]   count,
    output logic [ADDR_WIDTH-1:0]   ram_AA,
    output logic                    ram_CEA,
    output logic [ADDR_WIDTH-1:0]   ram_AB,
    output logic                    ram_CEB,
    output logic [DATA_WIDTH-1:0]   ram_DB,
    output logic [DATA_WIDTH-1:0]   ram_BWB,
    input  logic [DATA_WIDTH-1:0]   ram_QA
);

    localparam int unsigned PW = ADDR_WIDTH + 1;
    localparam int unsigned CW = ADDR_WIDTH + 2;
    localparam logic [PW-1:0] DEPTH = PW'(1) << ADDR_WIDTH;

    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         ram_cnt;
    logic                  inflight;
    logic [1:0]            out_cnt;
    logic [1:0]            out_occ;
    logic [DATA_WIDTH-1:0] out_buf0;
    logic [DATA_WIDTH-1:0] out_buf1;
    logic                  active;
    logic                  push_fire;
    logic                  pop_fire;
    logic                  room;
    logic                  issue;

    // Handshake and read-issue decisions, all taken from registered state
    // (plus push_valid for the optional bypass read).
    assign ram_cnt    = wr_ptr - rd_ptr;
    assign active     = rst_n & ~flush;
    assign push_ready = active & (ram_cnt != DEPTH);
    assign push_fire  = push_valid & push_ready;
    assign out_occ    = out_cnt + {1'b0, inflight};
    assign room       = (out_occ < 2'd2);

`ifdef DP_RAM_FIFO_WR_BYPASS_EN
    assign issue = active & room & ((ram_cnt != '0) | push_fire);
`else
    assign issue = active & room & (ram_cnt != '0);
`endif

    assign ram_CEA = issue;
    assign ram_AA  = rd_ptr[ADDR_WIDTH-1:0];
    assign ram_CEB = push_fire;
    assign ram_AB  = wr_ptr[ADDR_WIDTH-1:0];
    assign ram_DB  = push_data;
    assign ram_BWB = '1;

    assign pop_valid = (out_cnt != 2'd0);
    assign pop_data  = out_buf0;
    assign pop_fire  = pop_valid & pop_ready;
    assign count     = CW'(ram_cnt) + CW'(inflight) + CW'(out_cnt);

    // Pointer and read-pipeline state; flush and reset drop everything.
    always_ff @(posedge CLK) begin
        if (!rst_n || flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            inflight <= 1'b0;
        end else begin
            if (push_fire) wr_ptr <= wr_ptr + PW'(1);
            if (issue)     rd_ptr <= rd_ptr + PW'(1);
            inflight <= issue;
        end
    end

    // Output stage: returning read data enters at the tail, pops leave from the head.
    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            out_cnt  <= 2'd0;
            out_buf0 <= '0;
            out_buf1 <= '0;
        end else if (flush) begin
            out_cnt <= 2'd0;
        end else begin
            unique case ({inflight, pop_fire})
                2'b10: begin
                    if (out_cnt == 2'd0) out_buf0 <= ram_QA;
                    else                 out_buf1 <= ram_QA;
                    out_cnt <= out_cnt + 2'd1;
                end
                2'b01: begin
                    out_buf0 <= out_buf1;
                    out_cnt  <= out_cnt - 2'd1;
                end
                2'b11: begin
                    if (out_cnt == 2'd1) begin
                        out_buf0 <= ram_QA;
                    end else begin
                        out_buf0 <= out_buf1;
                        out_buf1 <= ram_QA;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
